// File: rtl/llc_req_frontend.sv
// LLC request front end: buffers trace commands, splits addresses into tag/index/offset,
// issues one request at a time to the cache core and keeps access statistics.
module llc_req_frontend #(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned BYTE_BITS  = 6,
    parameter int unsigned TAG_BITS   = ADDR_SIZE - INDEX_BITS - BYTE_BITS,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_SIZE-1:0]  in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_op,
    output logic [TAG_BITS-1:0]   out_tag,
    output logic [INDEX_BITS-1:0] out_index,
    output logic [BYTE_BITS-1:0]  out_offset,
    input  logic                  rsp_valid,
    input  logic [1:0]            rsp_result,
    output logic [31:0]           read_cnt,
    output logic [31:0]           write_cnt,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [15:0]           err_cnt,
    output logic                  stats_snap
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_READ    = 4'd0;
    localparam logic [3:0] OP_WRITE   = 4'd1;
    localparam logic [3:0] OP_IFETCH  = 4'd2;
    localparam logic [3:0] OP_LAST_FW = 4'd6;
    localparam logic [3:0] OP_BAD7    = 4'd7;
    localparam logic [3:0] OP_CLEAR   = 4'd8;
    localparam logic [3:0] OP_PRINT   = 4'd9;
    localparam logic [1:0] RSP_HIT    = 2'd1;
    localparam logic [1:0] RSP_MISS   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state, state_d;

    logic [3:0]           fifo_op   [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0] fifo_addr [FIFO_DEPTH];
    logic [CNT_W-1:0]     wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;

    logic                 fifo_empty, push, pop;
    logic [3:0]           head_op;
    logic [ADDR_SIZE-1:0] head_addr;
    logic                 head_fwd, head_bad, clear, issue_hs, rsp_counted;
    logic                 out_valid_d, snap_d;
    logic [31:0]          read_d, write_d, hit_d, miss_d;
    logic [15:0]          err_d;

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Command FIFO: pointers carry one wrap bit so full and empty are distinguishable
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head_op    = fifo_op[rd_ptr[PTR_W-1:0]];
    assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign wr_ptr_d   = wr_ptr + CNT_W'(push);
    assign rd_ptr_d   = rd_ptr + CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr[PTR_W-1:0]]   <= in_op;
            fifo_addr[wr_ptr[PTR_W-1:0]] <= in_addr;
        end
    end

    // in_ready looks only at next occupancy, so a pop never frees a slot in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            in_ready <= ((wr_ptr_d - rd_ptr_d) != CNT_W'(FIFO_DEPTH));
        end
    end

    assign head_fwd    = (head_op <= OP_LAST_FW);
    assign head_bad    = (head_op == OP_BAD7) || (head_op > OP_PRINT);
    assign clear       = pop && (head_op == OP_CLEAR);
    assign issue_hs    = (state == S_ISSUE) && out_ready;
    assign rsp_counted = (state == S_WAIT) && rsp_valid && (out_op <= OP_IFETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        out_valid_d = 1'b0;
        snap_d      = 1'b0;
        read_d      = read_cnt;
        write_d     = write_cnt;
        hit_d       = hit_cnt;
        miss_d      = miss_cnt;
        err_d       = err_cnt;
        case (state)
            S_IDLE: begin
                if (pop && head_fwd) begin
                    state_d = S_ISSUE;
                end
                if (pop && head_bad) begin
                    err_d = sat16(err_cnt);
                end
                if (pop && (head_op == OP_PRINT)) begin
                    snap_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue_hs && ((out_op == OP_READ) || (out_op == OP_IFETCH))) begin
            read_d = sat32(read_cnt);
        end
        if (issue_hs && (out_op == OP_WRITE)) begin
            write_d = sat32(write_cnt);
        end
        if (rsp_counted && (rsp_result == RSP_HIT)) begin
            hit_d = sat32(hit_cnt);
        end
        if (rsp_counted && (rsp_result == RSP_MISS)) begin
            miss_d = sat32(miss_cnt);
        end
        if (clear) begin
            read_d  = '0;
            write_d = '0;
            hit_d   = '0;
            miss_d  = '0;
            err_d   = '0;
        end
        out_valid_d = (state_d == S_ISSUE);
    end

    // Output registers; request fields stay put from pop until the next forwarded pop
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_tag    <= '0;
            out_index  <= '0;
            out_offset <= '0;
            read_cnt   <= '0;
            write_cnt  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            err_cnt    <= '0;
            stats_snap <= 1'b0;
        end else begin
            out_valid  <= out_valid_d;
            read_cnt   <= read_d;
            write_cnt  <= write_d;
            hit_cnt    <= hit_d;
            miss_cnt   <= miss_d;
            err_cnt    <= err_d;
            stats_snap <= snap_d;
            if (pop && head_fwd) begin
                out_op     <= head_op;
                out_tag    <= head_addr[ADDR_SIZE-1 -: TAG_BITS];
                out_index  <= head_addr[BYTE_BITS +: INDEX_BITS];
                out_offset <= head_addr[BYTE_BITS-1:0];
            end
        end
    end

endmodule
